// File: rtl/gift_cofb_keyarrange_inv_if.sv
// Request/response handshake bundle for the inverse key-arrange block.
// The requester uses the master modport and the block uses the slave modport.
interface gift_cofb_keyarrange_inv_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic [1:0]  req_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req_data, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/gift_cofb_keyarrange_inv.sv
// Iterative inverse of the GIFT-COFB fixsliced key arrangement: it undoes the
// four swapmove stages of the selected arrangement in reverse order, UNROLL stages per clock.
module gift_cofb_keyarrange_inv #(
  parameter int UNROLL = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  gift_cofb_keyarrange_inv_if.slave   kif,
  output logic                        busy
);

  localparam int         NSTEP     = 4 / UNROLL;
  localparam logic [1:0] LAST_STEP = 2'(NSTEP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] work_q;
  logic [31:0] rsp_q;
  logic [1:0]  sel_q;
  logic [1:0]  step_q;
  logic [31:0] round_val;
  logic [1:0]  idx;
  logic        req_ready;
  logic        rsp_valid;

  function automatic logic [31:0] swapmove(input logic [31:0] x,
                                           input logic [31:0] m,
                                           input logic [4:0]  a);
    logic [31:0] t;
    t = (x ^ (x >> a)) & m;
    return x ^ t ^ (t << a);
  endfunction

  // Each stage is its own inverse, so the forward table is reused verbatim.
  function automatic logic [31:0] apply_stage(input logic [31:0] x,
                                              input logic [1:0]  s,
                                              input logic [1:0]  i);
    logic [31:0] m;
    logic [4:0]  a;
    m = 32'h0000_00ff;
    a = 5'd24;
    case ({s, i})
      4'h0: begin m = 32'h0055_0055; a = 5'd9;  end
      4'h1: begin m = 32'h0000_3333; a = 5'd18; end
      4'h2: begin m = 32'h000f_000f; a = 5'd12; end
      4'h4: begin m = 32'h1111_1111; a = 5'd3;  end
      4'h5: begin m = 32'h0303_0303; a = 5'd6;  end
      4'h6: begin m = 32'h000f_000f; a = 5'd12; end
      4'h8: begin m = 32'h0000_aaaa; a = 5'd15; end
      4'h9: begin m = 32'h0000_3333; a = 5'd18; end
      4'ha: begin m = 32'h0000_f0f0; a = 5'd12; end
      4'hc: begin m = 32'h0a0a_0a0a; a = 5'd3;  end
      4'hd: begin m = 32'h00cc_00cc; a = 5'd6;  end
      4'he: begin m = 32'h0000_f0f0; a = 5'd12; end
      default: begin m = 32'h0000_00ff; a = 5'd24; end
    endcase
    return swapmove(x, m, a);
  endfunction

  // Stages of one step run from index 3 - step*UNROLL downward.
  always_comb begin
    round_val = work_q;
    idx       = 2'd0;
    for (int u = 0; u < UNROLL; u++) begin
      idx       = 2'(3 - int'(step_q) * UNROLL - u);
      round_val = apply_stage(round_val, sel_q, idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (kif.req_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (step_q == LAST_STEP) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (kif.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The response register loads only on the final RUN step, so it holds under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      rsp_q  <= '0;
      sel_q  <= '0;
      step_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (kif.req_valid) begin
            work_q <= kif.req_data;
            sel_q  <= kif.req_sel;
            step_q <= '0;
          end
        end
        RUN: begin
          work_q <= round_val;
          if (step_q == LAST_STEP) rsp_q  <= round_val;
          else                     step_q <= step_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign kif.req_ready = req_ready;
  assign kif.rsp_valid = rsp_valid;
  assign kif.rsp_data  = rsp_q;

endmodule

// File: tb/tb_gift_cofb_keyarrange_inv.sv
// Bench for gift_cofb_keyarrange_inv: directed vectors, round trips through a forward
// model for UNROLL 1/2/4, backpressure, and reset corner cases.
module tb_gift_cofb_keyarrange_inv;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid [3];
  logic        req_ready [3];
  logic [31:0] req_data  [3];
  logic [1:0]  req_sel   [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_data  [3];
  logic        busy      [3];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gift_cofb_keyarrange_inv_if kif ();
    assign kif.req_valid = req_valid[g];
    assign kif.req_data  = req_data[g];
    assign kif.req_sel   = req_sel[g];
    assign kif.rsp_ready = rsp_ready[g];
    assign req_ready[g]  = kif.req_ready;
    assign rsp_valid[g]  = kif.rsp_valid;
    assign rsp_data[g]   = kif.rsp_data;

    gift_cofb_keyarrange_inv #(.UNROLL(g == 0 ? 1 : (g == 1 ? 2 : 4))) dut (
      .clk  (clk),
      .rst  (rst),
      .kif  (kif),
      .busy (busy[g])
    );
  end

  localparam logic [31:0] FMASK [16] = '{
    32'h00550055, 32'h00003333, 32'h000f000f, 32'h000000ff,
    32'h11111111, 32'h03030303, 32'h000f000f, 32'h000000ff,
    32'h0000aaaa, 32'h00003333, 32'h0000f0f0, 32'h000000ff,
    32'h0a0a0a0a, 32'h00cc00cc, 32'h0000f0f0, 32'h000000ff};
  localparam int FSHIFT [16] = '{9, 18, 12, 24, 3, 6, 12, 24,
                                 15, 18, 12, 24, 3, 6, 12, 24};

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] data;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [31:0] fwd(input logic [31:0] x0, input int s);
    logic [31:0] x, t, m;
    int a;
    x = x0;
    for (int i = 0; i < 4; i++) begin
      m = FMASK[s*4+i];
      a = FSHIFT[s*4+i];
      t = (x ^ (x >> a)) & m;
      x = x ^ t ^ (t << a);
    end
    return x;
  endfunction

  function automatic int exp_lat(input int u);
    return (u == 0) ? 4 : ((u == 1) ? 2 : 1);
  endfunction

  task automatic checkOutput(input string name, input int u,
                             input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("[TB] FAIL %s inst=%0d actual=%h required=%h", name, u, act, exp_v);
    end
  endtask

  // Entered and left at #1 after a rising edge; hold=1 leaves the result un-acknowledged.
  task automatic applyStimulus(input int u, input logic [1:0] s, input logic [31:0] d,
                               input bit hold, output logic [31:0] res, output int lat);
    bit got;
    checkOutput("req_ready_idle", u, 32'(req_ready[u]), 32'd1);
    req_valid[u] = 1'b1;
    req_sel[u]   = s;
    req_data[u]  = d;
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    req_sel[u]   = ~s;
    req_data[u]  = ~d;
    got = 1'b0;
    lat = 0;
    res = 32'hxxxx_xxxx;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid[u]) got = 1'b1;
    end
    if (!got) begin
      lat = -1;
    end else begin
      res = rsp_data[u];
      if (!hold) begin
        rsp_ready[u] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[u] = 1'b0;
      end
    end
  endtask

  task automatic roundTrip(input int u);
    logic [31:0] orig, res;
    int lat;
    for (int n = 0; n < 1000; n++) begin
      for (int s = 0; s < 4; s++) begin
        orig = $urandom;
        applyStimulus(u, 2'(s), fwd(orig, s), 1'b0, res, lat);
        checkOutput("roundtrip_data", u, res, orig);
        checkOutput("roundtrip_latency", u, 32'(lat), 32'(exp_lat(u)));
      end
    end
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] res, orig;
    int lat;
    int seen;

    vecs[0] = '{2'd0, 32'h00000000, 32'h00000000};
    vecs[1] = '{2'd1, 32'h00000000, 32'h00000000};
    vecs[2] = '{2'd2, 32'h00000000, 32'h00000000};
    vecs[3] = '{2'd3, 32'h00000000, 32'h00000000};
    vecs[4] = '{2'd0, 32'hffffffff, 32'hffffffff};
    vecs[5] = '{2'd1, 32'hffffffff, 32'hffffffff};
    vecs[6] = '{2'd2, 32'hffffffff, 32'hffffffff};
    vecs[7] = '{2'd3, 32'hffffffff, 32'hffffffff};
    vecs[8] = '{2'd0, 32'h00000001, 32'h01000000};
    vecs[9] = '{2'd1, 32'h00000008, 32'h01000000};

    for (int u = 0; u < 3; u++) begin
      req_valid[u] = 1'b0;
      req_data[u]  = '0;
      req_sel[u]   = '0;
      rsp_ready[u] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int u = 0; u < 3; u++) begin
      checkOutput("reset_req_ready", u, 32'(req_ready[u]), 32'd1);
      checkOutput("reset_rsp_valid", u, 32'(rsp_valid[u]), 32'd0);
      checkOutput("reset_rsp_data",  u, rsp_data[u], 32'd0);
      checkOutput("reset_busy",      u, 32'(busy[u]), 32'd0);
    end

    for (int u = 0; u < 3; u++) begin
      for (int v = 0; v < 10; v++) begin
        applyStimulus(u, vecs[v].sel, vecs[v].data, 1'b0, res, lat);
        checkOutput("vector_data", u, res, vecs[v].exp_val);
        checkOutput("vector_latency", u, 32'(lat), 32'(exp_lat(u)));
      end
    end

    fork
      roundTrip(0);
      roundTrip(1);
      roundTrip(2);
    join

    // Backpressure on the UNROLL=1 instance while the request side is scribbled on.
    orig = 32'hdeadbeef;
    applyStimulus(0, 2'd2, fwd(orig, 2), 1'b1, res, lat);
    checkOutput("bp_data", 0, res, orig);
    checkOutput("bp_latency", 0, 32'(lat), 32'd4);
    for (int k = 0; k < 10; k++) begin
      req_valid[0] = 1'b1;
      req_sel[0]   = 2'($urandom_range(0, 3));
      req_data[0]  = $urandom;
      @(posedge clk); #1;
      checkOutput("bp_hold_data", 0, rsp_data[0], orig);
      checkOutput("bp_req_ready", 0, 32'(req_ready[0]), 32'd0);
      checkOutput("bp_rsp_valid", 0, 32'(rsp_valid[0]), 32'd1);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b0;
    checkOutput("done_no_accept_busy", 0, 32'(busy[0]), 32'd0);
    checkOutput("done_no_accept_ready", 0, 32'(req_ready[0]), 32'd1);
    checkOutput("done_exit_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);

    // Reset while the UNROLL=1 instance is at step 1.
    req_valid[0] = 1'b1;
    req_sel[0]   = 2'd0;
    req_data[0]  = 32'h00000001;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrun_rst_busy", 0, 32'(busy[0]), 32'd0);
    checkOutput("midrun_rst_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
    checkOutput("midrun_rst_req_ready", 0, 32'(req_ready[0]), 32'd1);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rsp_valid[0]) seen++;
    end
    checkOutput("midrun_rst_no_rsp", 0, 32'(seen), 32'd0);

    // Reset wins over a simultaneous request.
    rst          = 1'b1;
    req_valid[0] = 1'b1;
    req_data[0]  = 32'h12345678;
    @(posedge clk); #1;
    rst          = 1'b0;
    req_valid[0] = 1'b0;
    checkOutput("rst_priority_busy", 0, 32'(busy[0]), 32'd0);
    checkOutput("rst_priority_ready", 0, 32'(req_ready[0]), 32'd1);

    applyStimulus(0, 2'd0, 32'h00000001, 1'b0, res, lat);
    checkOutput("post_rst_data", 0, res, 32'h01000000);
    checkOutput("post_rst_latency", 0, 32'(lat), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
